// File: rtl/ce_tracker.sv
// ce_tracker
//   Follows the strobe cadence of the Vector-06C clock generator. It rebuilds
//   the generator's 6-bit counter value (phase) from the pipe_ab edges. It then
//   checks that all seven strobes keep matching that phase: first for 64 cycles
//   before declaring lock, and then for as long as lock is held.
//
// Ports
//   clk24        in   24 MHz master clock; all logic on its rising edge
//   reset_n      in   synchronous active-low reset
//   ce12 .. ce1m5 in  registered generator strobes, sampled every clk24
//   err_clr      in   synchronous clear of err_count
//   locked       out  cadence verified and being tracked
//   phase[5:0]   out  reconstructed counter k for this cycle's strobes (0 in HUNT)
//   err          out  one-cycle pulse after a strobe mismatch while LOCKED
//   err_count    out  saturating count of LOCKED mismatches
module ce_tracker (
  input  logic       clk24,
  input  logic       reset_n,
  input  logic       ce12,
  input  logic       ce6,
  input  logic       ce6x,
  input  logic       ce3,
  input  logic       video_slice,
  input  logic       pipe_ab,
  input  logic       ce1m5,
  input  logic       err_clr,
  output logic       locked,
  output logic [5:0] phase,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Strobe pattern the generator drives when its counter equals p.
  // Bit order: {ce12, ce6, ce6x, ce3, video_slice, pipe_ab, ce1m5}.
  function automatic logic [6:0] expected_strobes(input logic [5:0] p);
    expected_strobes = {p[0],
                        p[1] & p[0],
                        p[1] & ~p[0],
                        p[2] & p[1] & ~p[0],
                        ~p[2],
                        p[5],
                        ~p[3] & p[2] & p[1] & ~p[0]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [1:0] state_p0;
  logic [5:0] match_cnt_p0;
  logic       prev_pipe;
  logic       prev_valid;

  logic [6:0] strobes;
  logic       match;
  logic       pipe_edge;
  logic       err_inc;

  always_comb begin
    strobes   = {ce12, ce6, ce6x, ce3, video_slice, pipe_ab, ce1m5};
    match     = (strobes == expected_strobes(phase));
    // prev_valid masks the first sample after reset, when prev_pipe is only the reset value.
    pipe_edge = prev_valid && (pipe_ab != prev_pipe);
    err_inc   = (state_p0 == LOCKED) && !match;
  end

  // ---- single register stage: every output is a flop ----
  always_ff @(posedge clk24) begin
    if (!reset_n) begin
      state_p0     <= HUNT;
      match_cnt_p0 <= 6'd0;
      prev_pipe    <= 1'b0;
      prev_valid   <= 1'b0;
      phase        <= 6'd0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      prev_pipe  <= pipe_ab;
      prev_valid <= 1'b1;
      err        <= err_inc;

      // A clear that coincides with a new error leaves that one error counted.
      if (err_clr)
        err_count <= err_inc ? 8'd1 : 8'd0;
      else if (err_inc)
        err_count <= sat_inc(err_count);

      case (state_p0)
        HUNT: begin
          // A rising pipe_ab marks k=32 and a falling one marks k=0. Phase then
          // runs one ahead, because it describes the next cycle's strobes.
          if (pipe_edge) begin
            state_p0     <= VERIFY;
            phase        <= pipe_ab ? 6'd33 : 6'd1;
            match_cnt_p0 <= 6'd0;
          end
        end
        VERIFY: begin
          if (match) begin
            phase <= phase + 6'd1;
            if (match_cnt_p0 == 6'd63) begin
              state_p0 <= LOCKED;
              locked   <= 1'b1;
            end else begin
              match_cnt_p0 <= match_cnt_p0 + 6'd1;
            end
          end else begin
            state_p0 <= HUNT;
            phase    <= 6'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            phase <= phase + 6'd1;
          end else begin
            state_p0 <= HUNT;
            phase    <= 6'd0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state_p0 <= HUNT;
          phase    <= 6'd0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ce_tracker.sv
// Testbench for ce_tracker: a generator model drives strobes from a free-running
// counter, and a behavioural reference of the tracker predicts every output.
module tb_ce_tracker;

  logic       clk24 = 1'b0;
  logic       reset_n;
  logic       ce12, ce6, ce6x, ce3, video_slice, pipe_ab, ce1m5;
  logic       err_clr;
  logic       locked;
  logic [5:0] phase;
  logic       err;
  logic [7:0] err_count;

  always #5 clk24 = ~clk24;

  ce_tracker dut (
    .clk24       (clk24),
    .reset_n     (reset_n),
    .ce12        (ce12),
    .ce6         (ce6),
    .ce6x        (ce6x),
    .ce3         (ce3),
    .video_slice (video_slice),
    .pipe_ab     (pipe_ab),
    .ce1m5       (ce1m5),
    .err_clr     (err_clr),
    .locked      (locked),
    .phase       (phase),
    .err         (err),
    .err_count   (err_count)
  );

  localparam logic [6:0] NONE      = 7'd0;
  localparam logic [6:0] FLIP_CE12 = 7'b1000000;
  localparam logic [6:0] FLIP_1M5  = 7'b0000001;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gen_k    = 0;

  // Reference-model state (mode: 0 hunting, 1 verifying, 2 locked).
  int m_mode = 0, m_phase = 0, m_run = 0, m_cnt = 0, m_vstart = 0;
  bit m_prev = 0, m_pvalid = 0, m_locked = 0, m_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Generator strobes for counter value k, written as counter arithmetic.
  // Order {ce12, ce6, ce6x, ce3, video_slice, pipe_ab, ce1m5}.
  function automatic logic [6:0] gen_strobes(input int k);
    gen_strobes = {k % 2 == 1, k % 4 == 3, k % 4 == 2, k % 8 == 6,
                   (k / 4) % 2 == 0, k >= 32, k % 16 == 6};
  endfunction

  task automatic model_step(input logic [6:0] s, input bit rstn, input bit clr);
    bit match, pipe, inc;
    pipe = s[1];
    if (!rstn) begin
      m_mode = 0; m_phase = 0; m_run = 0; m_cnt = 0;
      m_prev = 0; m_pvalid = 0; m_locked = 0; m_err = 0;
      return;
    end
    match = (s == gen_strobes(m_phase));
    inc   = 0;
    m_err = 0;
    if (m_mode == 0) begin
      if (m_pvalid && pipe != m_prev) begin
        m_mode = 1; m_phase = pipe ? 33 : 1; m_run = 0; m_vstart = cyc;
      end
    end else if (!match) begin
      if (m_mode == 2) begin m_err = 1; inc = 1; end
      m_mode = 0; m_phase = 0; m_locked = 0;
    end else begin
      m_phase = (m_phase + 1) % 64;
      if (m_mode == 1) begin
        m_run++;
        if (m_run == 64) begin m_mode = 2; m_locked = 1; end
      end
    end
    if (clr) m_cnt = inc ? 1 : 0;
    else if (inc && m_cnt < 255) m_cnt++;
    m_prev   = pipe;
    m_pvalid = 1;
  endtask

  // One clk24 cycle: drive the strobes for gen_k (with optional bit flips),
  // then check the registered outputs against the model.
  task automatic step(input logic [6:0] flip, input bit clr, input bit rstn);
    logic [6:0] s;
    s = gen_strobes(gen_k) ^ flip;
    {ce12, ce6, ce6x, ce3, video_slice, pipe_ab, ce1m5} = s;
    err_clr = clr;
    reset_n = rstn;
    @(posedge clk24);
    model_step(s, rstn, clr);
    #1;
    cyc++;
    gen_k = (gen_k + 1) % 64;
    check_eq("phase", 32'(phase), m_phase);
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("err_count", 32'(err_count), m_cnt);
    if (locked === 1'b1) check_eq("phase_vs_gen", 32'(phase), gen_k);
  endtask

  task automatic tick();
    step(NONE, 1'b0, 1'b1);
  endtask

  task automatic run_to_k(input int k);
    int n;
    n = 0;
    while (gen_k != k && n < 64) begin tick(); n++; end
  endtask

  // Call only while unlocked: lock must follow the starting edge by 65 cycles.
  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < 400) begin tick(); n++; end
    check_eq({tag, "_lock_seen"}, 32'(locked), 32'd1);
    check_eq({tag, "_lock_latency"}, cyc - m_vstart, 32'd65);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_phase"}, 32'(phase), 32'd0);
    check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int saved;
    logic [6:0] mask;
    reset_n = 1'b0; err_clr = 1'b0;
    {ce12, ce6, ce6x, ce3, video_slice, pipe_ab, ce1m5} = 7'd0;

    // Scenario 1: generator starts at k=0 right after reset; lock via rise at k=32.
    gen_k = 63;
    step(NONE, 1'b0, 1'b0);
    check_reset_outputs("s1_rst");
    wait_lock("s1");
    repeat (70) tick();

    // Scenario 2: release reset at k=40 with pipe_ab high; lock via the fall at k=0.
    gen_k = 39;
    step(NONE, 1'b0, 1'b0);
    check_reset_outputs("s2_rst");
    run_to_k(1);
    check_eq("s2_phase_after_fall", 32'(phase), 32'd1);
    wait_lock("s2");

    // Scenario 3: single ce1m5 glitch at k=20 while locked.
    run_to_k(20);
    step(FLIP_1M5, 1'b0, 1'b1);
    check_eq("s3_err", 32'(err), 32'd1);
    check_eq("s3_locked", 32'(locked), 32'd0);
    check_eq("s3_err_count", 32'(err_count), 32'd1);
    check_eq("s3_phase", 32'(phase), 32'd0);
    tick();
    check_eq("s3_err_one_cycle", 32'(err), 32'd0);
    wait_lock("s3");

    // Scenario 4: abort VERIFY by flipping ce12 on its 10th cycle.
    step(FLIP_CE12, 1'b0, 1'b1);
    saved = 32'(err_count);
    begin
      int n;
      n = 0;
      while (m_mode != 1 && n < 100) begin tick(); n++; end
    end
    repeat (9) tick();
    step(FLIP_CE12, 1'b0, 1'b1);
    check_eq("s4_err", 32'(err), 32'd0);
    check_eq("s4_err_count", 32'(err_count), saved);
    check_eq("s4_phase", 32'(phase), 32'd0);
    check_eq("s4_locked", 32'(locked), 32'd0);
    wait_lock("s4");

    // Scenario 5: 300 locked glitches saturate the counter, then err_clr cases.
    step(NONE, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      wait_lock("s5");
      repeat ($urandom_range(0, 15)) tick();
      mask = 7'($urandom_range(1, 127));
      step(mask, 1'b0, 1'b1);
    end
    check_eq("s5_saturated", 32'(err_count), 32'd255);
    wait_lock("s5b");
    mask = 7'($urandom_range(1, 127));
    step(mask, 1'b1, 1'b1);
    check_eq("s5_clr_with_glitch", 32'(err_count), 32'd1);
    step(NONE, 1'b1, 1'b1);
    check_eq("s5_clr_alone", 32'(err_count), 32'd0);

    // Scenario 6: one reset cycle at k=50 while locked, then relock.
    wait_lock("s6a");
    run_to_k(50);
    step(NONE, 1'b0, 1'b0);
    check_reset_outputs("s6_rst");
    wait_lock("s6");

    // Random mix of glitches, clears and resets, checked cycle by cycle.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      mask = (r < 25) ? 7'($urandom_range(1, 127)) : NONE;
      step(mask, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, (r > 996) ? 1'b0 : 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
